bastim_int_ctrl: RTL and testbench
==================================

BASTIM_INT_CTRL -- requirements
Module: bastim_int_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the event counter and threshold.
REQ-002 ch_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 ch_rst  input  1  reset, asynchronous, active-high.
REQ-004 int_status_ch_reload  input  1  one-cycle reload event pulse from the basic-timer channel.
REQ-005 r_int_en  input  1  interrupt enable; 0 forces the block idle.
REQ-006 r_int_mode  input  1  0 = level IRQ, 1 = one-cycle pulse IRQ.
REQ-007 r_int_thresh  input  CNT_W  events required before the IRQ fires; 0 is treated as 1.
REQ-008 clr_req  input  1  one-cycle write-1-to-clear strobe from the register block.
REQ-009 irq  output  1  interrupt request to the NVIC line.
REQ-010 int_pending  output  1  high while the state is FIRE.
REQ-011 event_cnt  output  CNT_W  events accumulated since the last clear.
REQ-012 int_ovf  output  1  sticky flag: an event arrived while event_cnt was saturated.

Function
REQ-013 The FSM SHALL have three states: IDLE (event_cnt = 0), COLLECT (0 < event_cnt < threshold) and FIRE (threshold reached, awaiting clear).
REQ-014 Effective threshold thr = max(r_int_thresh, 1), sampled live every cycle without shadowing.
REQ-015 An event sampled at edge n SHALL update event_cnt to its new value at edge n.
REQ-016 The event SHALL be visible on event_cnt in cycle n+1.
REQ-017 If the new count is >= thr, the state SHALL become FIRE at the same edge.
REQ-018 Transitions:
- IDLE to COLLECT: event arrives and the new count is < thr.
- IDLE or COLLECT to FIRE: event arrives and the new count is >= thr.
- FIRE to IDLE: clr_req without a simultaneous event.
REQ-019 Events in FIRE SHALL keep incrementing event_cnt.
REQ-020 event_cnt SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-021 An event while event_cnt is saturated SHALL set int_ovf.
REQ-022 clr_req in any state SHALL zero event_cnt and int_ovf.
REQ-023 clr_req SHALL move the state to IDLE.
REQ-024 If clr_req and an event coincide, the clear SHALL apply first, then the event is counted: event_cnt = 1, next state FIRE if thr = 1, else COLLECT.
REQ-025 A threshold lowered in COLLECT to <= event_cnt SHALL move the state to FIRE at the next edge without needing an event.
REQ-026 A threshold raised while in FIRE SHALL NOT leave FIRE; only clr_req exits FIRE.
REQ-027 Level mode: irq SHALL be a registered output, high in every cycle the state is FIRE and r_int_en = 1.
REQ-028 Pulse mode: irq SHALL be high for exactly one cycle, the first cycle in FIRE.
REQ-029 Pulse mode: a clear followed by a re-entry to FIRE SHALL produce a new pulse.
REQ-030 A change of r_int_mode while in FIRE SHALL take effect next cycle.
REQ-031 A change of r_int_mode while in FIRE SHALL NOT generate an extra pulse.
REQ-032 While r_int_en = 0: state is IDLE, event_cnt is 0, irq is 0, events are ignored; int_ovf SHALL hold its value.
REQ-033 Deasserting r_int_en SHALL return the block to IDLE at the next edge.
REQ-034 int_pending SHALL be registered and equal (state == FIRE).

Reset
REQ-035 While ch_rst is high: state is IDLE; irq, int_pending, int_ovf are 0; event_cnt is 0.
REQ-036 Reset assertion SHALL take effect immediately, independent of ch_clk, including mid-FIRE.
REQ-037 After ch_rst deasserts, the first event sampled SHALL count as event 1.

Verification
REQ-038 thr=3, level mode, events at cycles 2, 5, 9 -> event_cnt 1, 2, 3 -> int_pending and irq high from cycle 10 until clr_req; clr_req -> all zero next cycle.
REQ-039 thr=1, pulse mode, event at cycle 4 -> irq high in cycle 5 only, int_pending stays high until clear.
REQ-040 CNT_W=8, thr=1, 260 events without clear -> event_cnt holds 255, int_ovf=1; clr_req -> event_cnt=0, int_ovf=0.
REQ-041 FIRE with clr_req and event in the same cycle, thr=2 -> state COLLECT, event_cnt=1, irq=0.
REQ-042 COLLECT with event_cnt=4, thr=8, r_int_thresh rewritten to 3 -> FIRE next cycle with no event.
REQ-043 ch_rst pulsed asynchronously mid-FIRE -> irq and int_pending drop without a clock edge; next event -> event_cnt=1.

Source files
------------

// File: rtl/bastim_int_ctrl.sv
// Basic-timer interrupt controller: counts reload events and raises a level or one-cycle IRQ at a threshold.
// Latency: an event at edge n is visible on event_cnt/int_pending/irq in cycle n+1; reset acts asynchronously.
// Backpressure: none; every reload pulse is counted, and events beyond saturation set the sticky int_ovf.
module bastim_int_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             ch_clk,
  input  logic             ch_rst,
  input  logic             int_status_ch_reload,
  input  logic             r_int_en,
  input  logic             r_int_mode,
  input  logic [CNT_W-1:0] r_int_thresh,
  input  logic             clr_req,
  output logic             irq,
  output logic             int_pending,
  output logic [CNT_W-1:0] event_cnt,
  output logic             int_ovf
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FIRE    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             fire_entry;
  logic             irq_nxt;

  always_comb begin
    thr        = (r_int_thresh == '0) ? CNT_ONE : r_int_thresh;
    // A coincident clear is applied before the event is counted.
    base_cnt   = clr_req ? '0 : event_cnt;
    cnt_nxt    = base_cnt;
    ovf_nxt    = clr_req ? 1'b0 : int_ovf;
    state_nxt  = state;
    fire_entry = 1'b0;
    irq_nxt    = 1'b0;

    if (!r_int_en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      if (int_status_ch_reload) begin
        if (base_cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = base_cnt + CNT_ONE;
        end
      end

      // FIRE is only left through a clear; a raised threshold never drops it.
      if ((state == ST_FIRE) && !clr_req) begin
        state_nxt = ST_FIRE;
      end else if (cnt_nxt >= thr) begin
        state_nxt = ST_FIRE;
      end else if (cnt_nxt == '0) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_COLLECT;
      end
    end

    // A clear that immediately re-fires counts as a fresh entry for pulse mode.
    fire_entry = (state_nxt == ST_FIRE) && ((state != ST_FIRE) || clr_req);
    irq_nxt    = (state_nxt == ST_FIRE) && (r_int_mode ? fire_entry : 1'b1);
  end

  always_ff @(posedge ch_clk or posedge ch_rst) begin
    if (ch_rst) begin
      state       <= ST_IDLE;
      event_cnt   <= '0;
      int_ovf     <= 1'b0;
      irq         <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      event_cnt   <= cnt_nxt;
      int_ovf     <= ovf_nxt;
      irq         <= irq_nxt;
      int_pending <= (state_nxt == ST_FIRE);
    end
  end

endmodule

// File: tb/tb_bastim_int_ctrl.sv
// Scenario bench for bastim_int_ctrl: expected outputs are queued as stimulus is applied and popped after the edge.
module tb_bastim_int_ctrl;

  localparam int CNT_W = 8;

  logic             ch_clk;
  logic             ch_rst;
  logic             int_status_ch_reload;
  logic             r_int_en;
  logic             r_int_mode;
  logic [CNT_W-1:0] r_int_thresh;
  logic             clr_req;
  logic             irq;
  logic             int_pending;
  logic [CNT_W-1:0] event_cnt;
  logic             int_ovf;

  typedef struct {
    string            name;
    logic             irq;
    logic             pend;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bastim_int_ctrl #(.CNT_W(CNT_W)) dut (
    .ch_clk               (ch_clk),
    .ch_rst               (ch_rst),
    .int_status_ch_reload (int_status_ch_reload),
    .r_int_en             (r_int_en),
    .r_int_mode           (r_int_mode),
    .r_int_thresh         (r_int_thresh),
    .clr_req              (clr_req),
    .irq                  (irq),
    .int_pending          (int_pending),
    .event_cnt            (event_cnt),
    .int_ovf              (int_ovf)
  );

  initial begin
    ch_clk = 1'b0;
    forever #5 ch_clk = ~ch_clk;
  end

  task automatic tick();
    @(posedge ch_clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic i, input logic p, input int c, input logic o);
    exp_t e;
    e.name = nm;
    e.irq  = i;
    e.pend = p;
    e.cnt  = CNT_W'(c);
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    ch_rst = 1'b1;
    int_status_ch_reload = 1'b0;
    r_int_en = 1'b0;
    r_int_mode = 1'b0;
    r_int_thresh = '0;
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp("reset", 1'b0, 1'b0, 0, 1'b0);
      if (i == 0) #2; else tick();
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    ch_rst = 1'b0;
    r_int_en = 1'b1;
  endtask

  task automatic test_level();
    exp_t e;
    int ecnt[12] = '{0, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 0};
    r_int_mode = 1'b0;
    r_int_thresh = 8'd3;
    for (int i = 0; i < 12; i++) begin
      int_status_ch_reload = (i == 1 || i == 4 || i == 8);
      clr_req = (i == 11);
      push_exp("level", (i >= 8 && i <= 10), (i >= 8 && i <= 10), ecnt[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s[%0d]: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, i, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    clr_req = 1'b0;
    int_status_ch_reload = 1'b0;
  endtask

  task automatic test_pulse();
    exp_t e;
    logic ev_t[13]   = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic clr_t[13]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic mode_t[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    logic irq_t[13]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    logic pend_t[13] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   cnt_t[13]  = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    r_int_thresh = 8'd1;
    for (int i = 0; i < 13; i++) begin
      int_status_ch_reload = ev_t[i];
      clr_req = clr_t[i];
      r_int_mode = mode_t[i];
      push_exp("pulse", irq_t[i], pend_t[i], cnt_t[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s[%0d]: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, i, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    clr_req = 1'b0;
    int_status_ch_reload = 1'b0;
    r_int_mode = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t e;
    r_int_mode = 1'b0;
    r_int_thresh = 8'd1;
    for (int k = 1; k <= 262; k++) begin
      clr_req = 1'b0;
      int_status_ch_reload = 1'b1;
      r_int_en = 1'b1;
      if (k <= 260) begin
        push_exp("saturate", 1'b1, 1'b1, (k > 255) ? 255 : k, (k > 255));
      end else if (k == 261) begin
        r_int_en = 1'b0;
        push_exp("disable_hold_ovf", 1'b0, 1'b0, 0, 1'b1);
      end else begin
        int_status_ch_reload = 1'b0;
        clr_req = 1'b1;
        push_exp("sat_clear", 1'b0, 1'b0, 0, 1'b0);
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s[%0d]: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, k, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    clr_req = 1'b0;
    int_status_ch_reload = 1'b0;
  endtask

  task automatic test_clr_event();
    exp_t e;
    logic ev_t[6]   = '{1, 1, 1, 1, 1, 0};
    logic clr_t[6]  = '{0, 0, 1, 0, 1, 1};
    int   thr_t[6]  = '{2, 2, 2, 1, 1, 1};
    logic fire_t[6] = '{0, 1, 0, 1, 1, 0};
    int   cnt_t[6]  = '{1, 2, 1, 2, 1, 0};
    r_int_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int_status_ch_reload = ev_t[i];
      clr_req = clr_t[i];
      r_int_thresh = CNT_W'(thr_t[i]);
      push_exp("clr_event", fire_t[i], fire_t[i], cnt_t[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s[%0d]: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, i, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    clr_req = 1'b0;
    int_status_ch_reload = 1'b0;
  endtask

  task automatic test_thresh();
    exp_t e;
    logic ev_t[10]   = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    logic clr_t[10]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    int   thr_t[10]  = '{8, 8, 8, 8, 3, 200, 200, 0, 0, 0};
    logic fire_t[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    int   cnt_t[10]  = '{1, 2, 3, 4, 4, 4, 0, 0, 1, 0};
    r_int_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      int_status_ch_reload = ev_t[i];
      clr_req = clr_t[i];
      r_int_thresh = CNT_W'(thr_t[i]);
      push_exp("thresh", fire_t[i], fire_t[i], cnt_t[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s[%0d]: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, i, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    clr_req = 1'b0;
    int_status_ch_reload = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    r_int_mode = 1'b0;
    r_int_thresh = 8'd1;
    for (int i = 0; i < 4; i++) begin
      int_status_ch_reload = 1'b0;
      clr_req = 1'b0;
      case (i)
        0: begin
          int_status_ch_reload = 1'b1;
          push_exp("pre_reset_fire", 1'b1, 1'b1, 1, 1'b0);
          tick();
        end
        1: begin
          push_exp("async_reset", 1'b0, 1'b0, 0, 1'b0);
          #3 ch_rst = 1'b1;
          #1;
        end
        2: begin
          int_status_ch_reload = 1'b1;
          #2 ch_rst = 1'b0;
          push_exp("post_reset_event", 1'b1, 1'b1, 1, 1'b0);
          tick();
        end
        default: begin
          clr_req = 1'b1;
          push_exp("post_reset_clear", 1'b0, 1'b0, 0, 1'b0);
          tick();
        end
      endcase
      e = sb.pop_front();
      n_tests++;
      if (irq !== e.irq || int_pending !== e.pend || event_cnt !== e.cnt || int_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s: got irq=%0b pend=%0b cnt=%0d ovf=%0b, expected irq=%0b pend=%0b cnt=%0d ovf=%0b",
                 e.name, irq, int_pending, event_cnt, int_ovf, e.irq, e.pend, e.cnt, e.ovf);
      end
    end
    clr_req = 1'b0;
    int_status_ch_reload = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_saturate();
    test_clr_event();
    test_thresh();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
